// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the writable instruction memory.
package instr_mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic        perr;
  } fetch_rsp_t;

  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_mem_pipe_if.sv
// Fetch, program-load and status signals between core and instruction memory.
// o_perr exists only when INSTR_MEM_PARITY_EN is defined.
interface instr_mem_pipe_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              o_ready;
  logic              o_valid;
  logic [31:0]       o_data;
  logic              o_fault;
  logic              i_flush;
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [31:0]       i_wdata;
  logic              o_init_done;
`ifdef INSTR_MEM_PARITY_EN
  logic              o_perr;
`endif

  modport master (
    output i_req, i_addr, i_flush, i_we, i_waddr, i_wdata,
`ifdef INSTR_MEM_PARITY_EN
    input  o_perr,
`endif
    input  o_ready, o_valid, o_data, o_fault, o_init_done
  );

  modport slave (
    input  i_req, i_addr, i_flush, i_we, i_waddr, i_wdata,
`ifdef INSTR_MEM_PARITY_EN
    output o_perr,
`endif
    output o_ready, o_valid, o_data, o_fault, o_init_done
  );

endinterface

// File: rtl/instr_mem_ram.sv
// Single-clock 1W/1R array with registered, read-before-write read port.
module instr_mem_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Only the read register is reset so the fetch outputs come up as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// Writable instruction memory with post-reset fill, fault checks and a 1/2-stage
// fetch pipeline. Optional stored parity under INSTR_MEM_PARITY_EN.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] FILL_WORD = NOP_INSTR
) (
  input logic             clk,
  input logic             rst,
  instr_mem_pipe_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned DATA_W = 33;
`else
  localparam int unsigned DATA_W = 32;
`endif

  function automatic logic [DATA_W-1:0] encode(input logic [31:0] d);
`ifdef INSTR_MEM_PARITY_EN
    return {even_parity(d), d};
`else
    return d;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_we;
  logic             ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == READY);

  logic rd_misal, rd_oor, wr_misal, wr_oor;
  assign rd_misal = |bus.i_addr[1:0];
  assign wr_misal = |bus.i_waddr[1:0];

  // Address bits above the index range only exist when the byte space exceeds DEPTH.
  if (ADDR_W - 2 > IDX_W) begin : g_oor
    assign rd_oor = |bus.i_addr[ADDR_W-1:IDX_W+2];
    assign wr_oor = |bus.i_waddr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
  end

  logic              accept, usr_we, ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign accept    = bus.i_req & ready & ~bus.i_flush;
  assign usr_we    = bus.i_we & ready & ~wr_misal & ~wr_oor;
  assign ram_we    = init_we | usr_we;
  assign ram_waddr = init_we ? cnt_q : bus.i_waddr[IDX_W+1:2];
  assign ram_wdata = init_we ? encode(FILL_WORD) : encode(bus.i_wdata);

  instr_mem_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (accept),
    .raddr(bus.i_addr[IDX_W+1:2]),
    .rdata(ram_rdata)
  );

  logic       v1_q, fault1_q;
  fetch_rsp_t rsp1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      fault1_q <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) fault1_q <= rd_misal | rd_oor;
    end
  end

  always_comb begin
    rsp1       = '0;
    rsp1.fault = fault1_q;
    rsp1.data  = fault1_q ? 32'h0 : ram_rdata[31:0];
`ifdef INSTR_MEM_PARITY_EN
    rsp1.perr  = ~fault1_q & (^ram_rdata);
`else
    rsp1.perr  = 1'b0;
`endif
  end

  logic       v_out;
  fetch_rsp_t rsp_out;

  if (LATENCY == 2) begin : g_lat2
    logic       v2_q;
    fetch_rsp_t rsp2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q   <= 1'b0;
        rsp2_q <= '0;
      end else begin
        v2_q <= v1_q & ~bus.i_flush;
        if (v1_q & ~bus.i_flush) rsp2_q <= rsp1;
      end
    end

    assign v_out   = v2_q;
    assign rsp_out = rsp2_q;
  end else begin : g_lat1
    assign v_out   = v1_q;
    assign rsp_out = rsp1;
  end

  // A flush also hides a response that would surface in the flush cycle itself.
  assign bus.o_valid     = v_out & ~bus.i_flush;
  assign bus.o_data      = rsp_out.data;
  assign bus.o_fault     = rsp_out.fault;
  assign bus.o_ready     = ready;
  assign bus.o_init_done = ready;
`ifdef INSTR_MEM_PARITY_EN
  assign bus.o_perr      = rsp_out.perr;
`else
  logic unused_perr;
  assign unused_perr = rsp_out.perr;
`endif

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench: runs a LATENCY=1 and a LATENCY=2 instance side by side on the
// same stimulus (DEPTH=16, ADDR_W=8). Parity checks need INSTR_MEM_PARITY_EN.
module tb_instr_mem_pipe;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 8;

  logic clk;
  logic rst;
  logic req, flush, we;
  logic [ADDR_W-1:0] addr, waddr;
  logic [31:0] wdata;

  int n_chk = 0;
  int n_err = 0;

  instr_mem_pipe_if #(.ADDR_W(ADDR_W)) bus1 ();
  instr_mem_pipe_if #(.ADDR_W(ADDR_W)) bus2 ();

  assign bus1.i_req = req;   assign bus2.i_req = req;
  assign bus1.i_addr = addr;  assign bus2.i_addr = addr;
  assign bus1.i_flush = flush; assign bus2.i_flush = flush;
  assign bus1.i_we = we;     assign bus2.i_we = we;
  assign bus1.i_waddr = waddr; assign bus2.i_waddr = waddr;
  assign bus1.i_wdata = wdata; assign bus2.i_wdata = wdata;

  instr_mem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  instr_mem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples both instances at the falling edge; data/fault checked only when valid expected.
  task automatic expect_out(input string tag,
                            input logic v1e, input logic [31:0] d1e, input logic f1e,
                            input logic v2e, input logic [31:0] d2e, input logic f2e);
    @(negedge clk);
    check_val({tag, "/v1"}, 32'(bus1.o_valid), 32'(v1e));
    if (v1e) begin
      check_val({tag, "/d1"}, bus1.o_data, d1e);
      check_val({tag, "/f1"}, 32'(bus1.o_fault), 32'(f1e));
    end
    check_val({tag, "/v2"}, 32'(bus2.o_valid), 32'(v2e));
    if (v2e) begin
      check_val({tag, "/d2"}, bus2.o_data, d2e);
      check_val({tag, "/f2"}, 32'(bus2.o_fault), 32'(f2e));
    end
  endtask

  task automatic run_init(input string tag);
    int  n;
    logic vseen;
    n = 0;
    vseen = 1'b0;
    while (!bus1.o_init_done && n < 200) begin
      tick();
      n++;
      vseen = vseen | bus1.o_valid | bus2.o_valid;
    end
    check_val({tag, "/len"}, 32'(n), 32'(DEPTH));
    check_val({tag, "/done2"}, 32'(bus2.o_init_done), 32'd1);
    check_val({tag, "/ready"}, 32'(bus1.o_ready), 32'd1);
    check_val({tag, "/novalid"}, 32'(vseen), 32'd0);
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; we = 1'b0;
    addr = '0; waddr = '0; wdata = '0;
    tick();
    tick();
    @(negedge clk);
    check_val("rst/valid", 32'({bus1.o_valid, bus2.o_valid}), 32'd0);
    check_val("rst/data1", bus1.o_data, 32'h0);
    check_val("rst/data2", bus2.o_data, 32'h0);
    check_val("rst/fault", 32'({bus1.o_fault, bus2.o_fault}), 32'd0);
    check_val("rst/ready", 32'({bus1.o_ready, bus2.o_ready}), 32'd0);
    check_val("rst/done", 32'({bus1.o_init_done, bus2.o_init_done}), 32'd0);
    rst = 1'b0;
    run_init("init");

    // First fetch after INIT returns the fill word
    req = 1'b1; addr = 8'h00;
    tick(); req = 1'b0;
    expect_out("nop_a", 1, NOP, 0, 0, 0, 0);
    tick();
    expect_out("nop_b", 0, 0, 0, 1, NOP, 0);

    // Program load, then back-to-back fetches
    we = 1'b1; waddr = 8'h00; wdata = 32'h00000093;
    tick(); waddr = 8'h08; wdata = 32'h00208f33;
    tick(); we = 1'b0;
    req = 1'b1; addr = 8'h00;
    tick(); addr = 8'h04;
    expect_out("b2b_0", 1, 32'h00000093, 0, 0, 0, 0);
    tick(); addr = 8'h08;
    expect_out("b2b_1", 1, NOP, 0, 1, 32'h00000093, 0);
    tick(); req = 1'b0;
    expect_out("b2b_2", 1, 32'h00208f33, 0, 1, NOP, 0);
    tick();
    expect_out("b2b_3", 0, 0, 0, 1, 32'h00208f33, 0);
    tick();
    expect_out("b2b_4", 0, 0, 0, 0, 0, 0);

    // Misaligned and out-of-range fetches
    req = 1'b1; addr = 8'h02;
    tick(); addr = 8'h40;
    expect_out("flt_0", 1, 0, 1, 0, 0, 0);
    tick(); req = 1'b0;
    expect_out("flt_1", 1, 0, 1, 1, 0, 1);
    tick();
    expect_out("flt_2", 0, 0, 0, 1, 0, 1);

    // Bad-address writes must not alias onto word 0 or word DEPTH-1
    we = 1'b1; waddr = 8'h02; wdata = 32'hBAD0BAD0;
    tick(); waddr = 8'h40;
    tick(); waddr = 8'h3F;
    tick(); we = 1'b0;
    req = 1'b1; addr = 8'h00;
    tick(); addr = 8'h3C;
    expect_out("bwr_0", 1, 32'h00000093, 0, 0, 0, 0);
    tick(); req = 1'b0;
    expect_out("bwr_1", 1, NOP, 0, 1, 32'h00000093, 0);
    tick();
    expect_out("bwr_2", 0, 0, 0, 1, NOP, 0);

    // Same-cycle read and write: old data first, new data next
    we = 1'b1; waddr = 8'h10; wdata = 32'hDEADBEEF;
    req = 1'b1; addr = 8'h10;
    tick(); we = 1'b0;
    expect_out("rbw_0", 1, NOP, 0, 0, 0, 0);
    tick(); req = 1'b0;
    expect_out("rbw_1", 1, 32'hDEADBEEF, 0, 1, NOP, 0);
    tick();
    expect_out("rbw_2", 0, 0, 0, 1, 32'hDEADBEEF, 0);

    // Flush one cycle after the second fetch; a request in the flush cycle is dropped
    req = 1'b1; addr = 8'h00;
    tick(); addr = 8'h04;
    expect_out("fl_0", 1, 32'h00000093, 0, 0, 0, 0);
    tick(); flush = 1'b1; addr = 8'h0C;
    expect_out("fl_1", 0, 0, 0, 0, 0, 0);
    tick(); flush = 1'b0; req = 1'b0;
    expect_out("fl_2", 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("fl_3", 0, 0, 0, 0, 0, 0);
    req = 1'b1; addr = 8'h08;
    tick(); req = 1'b0;
    expect_out("fl_4", 1, 32'h00208f33, 0, 0, 0, 0);
    tick();
    expect_out("fl_5", 0, 0, 0, 1, 32'h00208f33, 0);

    // Reset with fetches in flight
    req = 1'b1; addr = 8'h00;
    tick(); addr = 8'h04;
    tick(); req = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    expect_out("mrst", 0, 0, 0, 0, 0, 0);
    check_val("mrst/ready", 32'({bus1.o_ready, bus2.o_ready}), 32'd0);
    run_init("reinit");
    req = 1'b1; addr = 8'h00;
    tick(); req = 1'b0;
    expect_out("refill_a", 1, NOP, 0, 0, 0, 0);
    tick();
    expect_out("refill_b", 0, 0, 0, 1, NOP, 0);

`ifdef INSTR_MEM_PARITY_EN
    dut1.u_ram.mem_q[3][32] = ~dut1.u_ram.mem_q[3][32];
    dut2.u_ram.mem_q[3][32] = ~dut2.u_ram.mem_q[3][32];
    req = 1'b1; addr = 8'h0C;
    tick(); addr = 8'h08;
    expect_out("par_0", 1, NOP, 0, 0, 0, 0);
    check_val("par_0/perr1", 32'(bus1.o_perr), 32'd1);
    tick(); addr = 8'h0E;
    expect_out("par_1", 1, NOP, 0, 1, NOP, 0);
    check_val("par_1/perr1", 32'(bus1.o_perr), 32'd0);
    check_val("par_1/perr2", 32'(bus2.o_perr), 32'd1);
    tick(); req = 1'b0;
    expect_out("par_2", 1, 0, 1, 1, NOP, 0);
    check_val("par_2/perr1", 32'(bus1.o_perr), 32'd0);
    check_val("par_2/perr2", 32'(bus2.o_perr), 32'd0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
